// File: rtl/sequential_divider61_48.sv
// sequential_divider61_48: restoring divider, 61-bit dividend by 48-bit divisor, one quotient bit per cycle
module sequential_divider61_48 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [60:0] A,
    input  logic [47:0] B,
    output logic        busy,
    output logic        done,
    output logic [60:0] quotient,
    output logic [47:0] remainder,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;
    logic [60:0] a_reg, q;
    logic [47:0] b_reg, p;
    logic [5:0]  cnt;
    logic        dbz;
    logic [48:0] diff;
    always_comb begin
        // Partial remainder stays below the divisor, so the borrow out of the 49-bit trial subtract is the compare result
        diff = {p, a_reg[60]} - {1'b0, b_reg};
        state_next = (state == IDLE) ? (start ? ((B == '0) ? DONE : CALC) : IDLE) :
                     (state == CALC) ? ((cnt == '0) ? DONE : CALC) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            p     <= '0;
            q     <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
        end else if (state == IDLE && start) begin
            a_reg <= A;
            b_reg <= B;
            cnt   <= 6'd60;
            q     <= (B == '0) ? '1 : '0;
            p     <= (B == '0) ? A[47:0] : '0;
            dbz   <= (B == '0);
        end else if (state == CALC) begin
            a_reg <= {a_reg[59:0], 1'b0};
            q     <= {q[59:0], ~diff[48]};
            p     <= diff[48] ? {p[46:0], a_reg[60]} : diff[47:0];
            cnt   <= cnt - 6'd1;
        end
    end
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign quotient    = q;
    assign remainder   = p;
    assign div_by_zero = dbz;
endmodule
